ahb_master_arbiter: RTL and testbench

Two-master AHB-Lite arbiter that shares the single SoC bus (interconnect plus instruction and data slaves) between the RISC-V core master (M0) and a boot/DMA master (M1). The boot/DMA master is the boot loader that writes program bytes before the core runs. The block sits between the masters and the AHB interconnect. It registers the grant, muxes address-phase and data-phase signals, and routes `hresp` back to the master that owns the data phase. Round-robin arbitration with a hold limit prevents either master from starving the other.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_rr_picker.sv | 39 +++
 rtl/ahb_master_arbiter.sv | 124 ++++++++++++
 tb/tb_ahb_master_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and master identifiers for the bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef logic master_id_t;

    localparam master_id_t M_CORE = 1'b0;
    localparam master_id_t M_BOOT = 1'b1;

    // Address-phase ownership; the encoding is the owning master id.
    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } own_state_t;

    // SEQ and BUSY continue a burst; the bus must not change hands there.
    function automatic logic is_mid_burst(input logic [1:0] trans);
        return (trans == SEQ) || (trans == BUSY);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational next-owner selection: burst protection, parking,
// single-requester handover, round-robin on contention and hold limit.
module ahb_rr_picker import ahb_pkg::*; #(
    parameter master_id_t PARK_ID = M_CORE
) (
    input  logic       hbusreq_m0,
    input  logic       hbusreq_m1,
    input  master_id_t owner,
    input  master_id_t last_grant,
    input  logic [1:0] owner_htrans,
    input  logic       hold_sat,
    output master_id_t next_owner
);

    logic req_own;
    logic req_oth;

    assign req_own = (owner == M_BOOT) ? hbusreq_m1 : hbusreq_m0;
    assign req_oth = (owner == M_BOOT) ? hbusreq_m0 : hbusreq_m1;

    // Pick the owner for the next address phase.
    always_comb begin
        next_owner = owner;
        if (is_mid_burst(owner_htrans)) begin
            next_owner = owner;
        end else if (!hbusreq_m0 && !hbusreq_m1) begin
            next_owner = PARK_ID;
        end else if (req_oth && !req_own) begin
            next_owner = ~owner;
        end else if (req_own && !req_oth) begin
            next_owner = owner;
        end else if (owner_htrans == IDLE) begin
            next_owner = ~last_grant;
        end else if (hold_sat) begin
            next_owner = ~owner;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: registered grant, address/data muxes and
// hresp routing to the data-phase owner.
module ahb_master_arbiter import ahb_pkg::*; #(
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned PARK_MASTER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hbusreq_m0,
    input  logic        hbusreq_m1,
    output logic        hgrant_m0,
    output logic        hgrant_m1,
    input  logic [31:0] haddr_m0,
    input  logic [1:0]  htrans_m0,
    input  logic        hwrite_m0,
    input  logic [2:0]  hsize_m0,
    input  logic [3:0]  hprot_m0,
    input  logic        is_signed_m0,
    input  logic [31:0] hwdata_m0,
    input  logic [31:0] haddr_m1,
    input  logic [1:0]  htrans_m1,
    input  logic        hwrite_m1,
    input  logic [2:0]  hsize_m1,
    input  logic [3:0]  hprot_m1,
    input  logic        is_signed_m1,
    input  logic [31:0] hwdata_m1,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic        is_signed,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        hready_m0,
    output logic        hready_m1,
    output logic        hresp_m0,
    output logic        hresp_m1,
    output logic        hmaster
);

    localparam master_id_t PARK_ID      = (PARK_MASTER != 0) ? M_BOOT : M_CORE;
    localparam own_state_t PARK_STATE   = own_state_t'(PARK_ID);
    localparam logic [3:0] HOLD_LIMIT   = 4'(MAX_HOLD);
    localparam logic [4:0] HOLD_LIMIT_W = 5'(MAX_HOLD);

    own_state_t state;
    master_id_t cur_owner;
    master_id_t hmaster_d;
    master_id_t last_grant;
    master_id_t next_owner;
    logic [3:0] hold_cnt;
    logic       accept;
    logic       hold_sat;

    assign cur_owner = master_id_t'(state);
    assign hmaster   = cur_owner;
    assign accept    = htrans[1] & hready;

    // Saturation includes the transfer accepted this cycle so the owner gets
    // exactly MAX_HOLD transfers, not MAX_HOLD+1, before handing over.
    assign hold_sat = ({1'b0, hold_cnt} + {4'b0, accept}) >= HOLD_LIMIT_W;

    ahb_rr_picker #(
        .PARK_ID (PARK_ID)
    ) u_picker (
        .hbusreq_m0   (hbusreq_m0),
        .hbusreq_m1   (hbusreq_m1),
        .owner        (cur_owner),
        .last_grant   (last_grant),
        .owner_htrans (htrans),
        .hold_sat     (hold_sat),
        .next_owner   (next_owner)
    );

    // Ownership FSM with registered grants; everything freezes on a wait state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= PARK_STATE;
            hmaster_d  <= PARK_ID;
            last_grant <= ~PARK_ID;
            hold_cnt   <= '0;
            hgrant_m0  <= (PARK_ID == M_CORE);
            hgrant_m1  <= (PARK_ID == M_BOOT);
        end else if (hready) begin
            state      <= own_state_t'(next_owner);
            hmaster_d  <= cur_owner;
            last_grant <= next_owner;
            hgrant_m0  <= (next_owner == M_CORE);
            hgrant_m1  <= (next_owner == M_BOOT);
            if (next_owner != cur_owner) begin
                hold_cnt <= '0;
            end else if (accept && (hold_cnt < HOLD_LIMIT)) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    // Address-phase mux selected by the registered owner.
    always_comb begin
        haddr     = haddr_m0;
        htrans    = htrans_m0;
        hwrite    = hwrite_m0;
        hsize     = hsize_m0;
        hprot     = hprot_m0;
        is_signed = is_signed_m0;
        if (state == OWN_M1) begin
            haddr     = haddr_m1;
            htrans    = htrans_m1;
            hwrite    = hwrite_m1;
            hsize     = hsize_m1;
            hprot     = hprot_m1;
            is_signed = is_signed_m1;
        end
    end

    assign hwdata    = (hmaster_d == M_BOOT) ? hwdata_m1 : hwdata_m0;
    assign hresp_m0  = hresp & (hmaster_d == M_CORE);
    assign hresp_m1  = hresp & (hmaster_d == M_BOOT);
    assign hready_m0 = hready;
    assign hready_m1 = hready;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed-vector bench for ahb_master_arbiter with a queue-based scoreboard.
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    localparam logic [31:0] W0    = 32'hDEAD_BEEF;
    localparam logic [31:0] W1    = 32'hCAFE_0001;
    // {hwrite, hsize, hprot, is_signed} per master
    localparam logic [8:0]  ATTR0 = {1'b1, 3'd2, 4'h3, 1'b0};
    localparam logic [8:0]  ATTR1 = {1'b0, 3'd0, 4'hA, 1'b1};

    logic        clk = 1'b0;
    logic        reset;
    logic        hbusreq_m0, hbusreq_m1;
    logic        hgrant_m0, hgrant_m1;
    logic [31:0] haddr_m0, haddr_m1;
    logic [1:0]  htrans_m0, htrans_m1;
    logic        hwrite_m0, hwrite_m1;
    logic [2:0]  hsize_m0, hsize_m1;
    logic [3:0]  hprot_m0, hprot_m1;
    logic        is_signed_m0, is_signed_m1;
    logic [31:0] hwdata_m0, hwdata_m1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        is_signed;
    logic [31:0] hwdata;
    logic        hready, hresp;
    logic        hready_m0, hready_m1;
    logic        hresp_m0, hresp_m1;
    logic        hmaster;

    always #5 clk = ~clk;

    assign {hwrite_m0, hsize_m0, hprot_m0, is_signed_m0} = ATTR0;
    assign {hwrite_m1, hsize_m1, hprot_m1, is_signed_m1} = ATTR1;
    assign hwdata_m0 = W0;
    assign hwdata_m1 = W1;

    ahb_master_arbiter #(
        .MAX_HOLD    (8),
        .PARK_MASTER (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hbusreq_m0   (hbusreq_m0),
        .hbusreq_m1   (hbusreq_m1),
        .hgrant_m0    (hgrant_m0),
        .hgrant_m1    (hgrant_m1),
        .haddr_m0     (haddr_m0),
        .htrans_m0    (htrans_m0),
        .hwrite_m0    (hwrite_m0),
        .hsize_m0     (hsize_m0),
        .hprot_m0     (hprot_m0),
        .is_signed_m0 (is_signed_m0),
        .hwdata_m0    (hwdata_m0),
        .haddr_m1     (haddr_m1),
        .htrans_m1    (htrans_m1),
        .hwrite_m1    (hwrite_m1),
        .hsize_m1     (hsize_m1),
        .hprot_m1     (hprot_m1),
        .is_signed_m1 (is_signed_m1),
        .hwdata_m1    (hwdata_m1),
        .haddr        (haddr),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .hsize        (hsize),
        .hprot        (hprot),
        .is_signed    (is_signed),
        .hwdata       (hwdata),
        .hready       (hready),
        .hresp        (hresp),
        .hready_m0    (hready_m0),
        .hready_m1    (hready_m1),
        .hresp_m0     (hresp_m0),
        .hresp_m1     (hresp_m1),
        .hmaster      (hmaster)
    );

    typedef struct {
        logic        chk;
        logic        eo;   // expected address-phase owner
        logic        eod;  // expected data-phase owner
        logic        rdy;
        logic        rsp;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  t0;
        logic [1:0]  t1;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                cmp("hmaster",   32'(hmaster), 32'(e.eo));
                cmp("hgrant",    32'({hgrant_m1, hgrant_m0}), 32'(e.eo ? 2'b10 : 2'b01));
                cmp("haddr",     haddr, e.eo ? e.a1 : e.a0);
                cmp("htrans",    32'(htrans), 32'(e.eo ? e.t1 : e.t0));
                cmp("attr",      32'({hwrite, hsize, hprot, is_signed}), 32'(e.eo ? ATTR1 : ATTR0));
                cmp("hwdata",    hwdata, e.eod ? W1 : W0);
                cmp("hresp_m0",  32'(hresp_m0), 32'(e.rsp & ~e.eod));
                cmp("hresp_m1",  32'(hresp_m1), 32'(e.rsp & e.eod));
                cmp("hready_mx", 32'({hready_m1, hready_m0}), 32'({e.rdy, e.rdy}));
            end
        end
    end

    task automatic step(input logic rst, input logic r0, input logic r1,
                        input logic [1:0] t0, input logic [1:0] t1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic rdy, input logic rsp,
                        input logic chk, input logic eo, input logic eod);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        hbusreq_m0 = r0;
        hbusreq_m1 = r1;
        htrans_m0  = t0;
        htrans_m1  = t1;
        haddr_m0   = a0;
        haddr_m1   = a1;
        hready     = rdy;
        hresp      = rsp;
        e = '{chk, eo, eod, rdy, rsp, a0, a1, t0, t1};
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b0; hbusreq_m0 = 1'b1; hbusreq_m1 = 1'b1;
        htrans_m0 = IDLE; htrans_m1 = IDLE;
        haddr_m0 = '0; haddr_m1 = '0; hready = 1'b1; hresp = 1'b0;

        // Reset held two cycles with both masters requesting
        step(0, 1, 1, IDLE,   IDLE,   32'h0,     32'h0,     1, 0, 1, 0, 0);
        step(0, 1, 1, IDLE,   IDLE,   32'h0,     32'h0,     1, 0, 1, 0, 0);
        // Release: M0 wins first contention
        step(1, 1, 1, IDLE,   IDLE,   32'h0,     32'h2000,  1, 0, 1, 0, 0);
        // Handover on idle
        step(1, 1, 1, NONSEQ, NONSEQ, 32'h100,   32'h2000,  1, 0, 1, 0, 0);
        step(1, 1, 1, IDLE,   NONSEQ, 32'h104,   32'h2000,  1, 0, 1, 0, 0);
        step(1, 0, 1, IDLE,   NONSEQ, 32'h104,   32'h2000,  1, 0, 1, 1, 0);
        // Error during M1 data phase, ownership unchanged
        step(1, 0, 1, IDLE,   IDLE,   32'h0,     32'h2004,  1, 1, 1, 1, 1);
        step(1, 0, 1, IDLE,   IDLE,   32'h0,     32'h2004,  1, 0, 1, 1, 1);
        // M1 drops request: hand back to M0 with a fresh hold count
        step(1, 1, 0, NONSEQ, IDLE,   32'h1000,  32'h2004,  1, 0, 1, 1, 1);
        // Hold limit: 8 transfers each, alternating
        for (int i = 0; i < 8; i++)
            step(1, 1, 1, NONSEQ, NONSEQ, 32'h1000 + 32'(4 * i), 32'h8000 + 32'(4 * i),
                 1, 0, 1, 0, (i == 0));
        for (int i = 0; i < 8; i++)
            step(1, 1, 1, NONSEQ, NONSEQ, 32'h1100 + 32'(4 * i), 32'h8100 + 32'(4 * i),
                 1, 0, 1, 1, (i != 0));
        // Burst protection: NONSEQ + 12 SEQ, hold count saturates mid-burst
        step(1, 1, 1, NONSEQ, NONSEQ, 32'h4000,  32'h9000,  1, 0, 1, 0, 1);
        for (int i = 0; i < 12; i++)
            step(1, 1, 1, SEQ, NONSEQ, 32'h4004 + 32'(4 * i), 32'h9000, 1, 0, 1, 0, 0);
        // Next NONSEQ boundary with saturated count hands over
        step(1, 1, 1, NONSEQ, NONSEQ, 32'h5000,  32'h9000,  1, 0, 1, 0, 0);
        step(1, 1, 1, IDLE,   NONSEQ, 32'h5000,  32'h9000,  1, 0, 1, 1, 0);
        // Wait states stall a handover back to M0
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, NONSEQ, IDLE, 32'h5000, 32'h9004, 0, 0, 1, 1, 1);
        step(1, 1, 0, NONSEQ, IDLE,   32'h5000,  32'h9004,  1, 0, 1, 1, 1);
        step(1, 1, 0, NONSEQ, IDLE,   32'h5004,  32'h9004,  1, 0, 1, 0, 1);
        step(1, 1, 0, NONSEQ, IDLE,   32'h5008,  32'h9004,  1, 0, 1, 0, 0);
        // Parking after M1 owns the bus and both requests drop
        step(1, 0, 1, IDLE,   IDLE,   32'h5008,  32'hA000,  1, 0, 1, 0, 0);
        step(1, 0, 0, IDLE,   IDLE,   32'h5008,  32'hA000,  1, 0, 1, 1, 0);
        step(1, 0, 0, IDLE,   IDLE,   32'h5008,  32'hA000,  1, 0, 1, 0, 1);
        // Error during M0 data phase
        step(1, 0, 0, IDLE,   IDLE,   32'h5008,  32'hA000,  1, 1, 1, 0, 0);
        // Reset while M1 owns the address phase
        step(1, 0, 1, IDLE,   NONSEQ, 32'h0,     32'hB000,  1, 0, 1, 0, 0);
        step(0, 0, 1, IDLE,   NONSEQ, 32'h0,     32'hB000,  1, 0, 1, 1, 0);
        step(1, 0, 1, IDLE,   NONSEQ, 32'h0,     32'hB000,  1, 0, 1, 0, 0);
        step(1, 0, 1, IDLE,   NONSEQ, 32'h0,     32'hB004,  1, 0, 1, 1, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        cmp("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
